// File: rtl/key_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_bank
// Description : NUM_KEYS-channel key debouncer with a shared sample tick,
//               press/release/long-press pulses and optional auto-repeat
//               (enabled by defining KEY_AUTO_REPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_bank #(
    parameter int NUM_KEYS   = 4,
    parameter int CLK_DIV    = 48000,
    parameter int STABLE_CNT = 32,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_CNT   = 1000,
    parameter int REPEAT_CNT = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    localparam int   c_DIV_W  = $clog2(CLK_DIV);
    localparam int   c_STAB_W = $clog2(STABLE_CNT);
    localparam int   c_HOLD_W = $clog2(LONG_CNT + 1);
    localparam logic c_AL_BIT = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } hold_state_t;

    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;

    assign w_tick = (r_div == c_DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) r_div <= '0;
        else               r_div <= r_div + c_DIV_W'(1);
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic [1:0]          r_sync;
        logic                w_sample;
        logic                w_flip;
        logic                w_rise;
        logic                w_fall;
        logic [c_STAB_W-1:0] r_stab;
        logic                r_level;
        logic                r_press;
        logic                r_release;
        hold_state_t         r_state;
        hold_state_t         w_state_nxt;
        logic [c_HOLD_W-1:0] r_hold;
        logic [c_HOLD_W-1:0] w_hold_nxt;
        logic                r_long;
        logic                w_long_nxt;

        // Synchroniser parks at the released pin level so reset never looks like a press.
        always_ff @(posedge clk) begin
            if (rst) r_sync <= {2{c_AL_BIT}};
            else     r_sync <= {r_sync[0], key[g]};
        end

        assign w_sample = r_sync[1] ^ c_AL_BIT;
        assign w_flip   = w_tick && (w_sample != r_level)
                          && (r_stab == c_STAB_W'(STABLE_CNT - 1));
        assign w_rise   = w_flip && !r_level;
        assign w_fall   = w_flip &&  r_level;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_level   <= 1'b0;
                r_stab    <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_rise;
                r_release <= w_fall;
                if (w_tick) begin
                    if ((w_sample == r_level) || w_flip) r_stab <= '0;
                    else                                 r_stab <= r_stab + c_STAB_W'(1);
                    if (w_flip) r_level <= ~r_level;
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold;
            w_long_nxt  = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_HELD;
                        w_hold_nxt  = '0;
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = '0;
                    end else if (w_tick) begin
                        if (r_hold == c_HOLD_W'(LONG_CNT - 1)) begin
                            w_hold_nxt  = c_HOLD_W'(LONG_CNT);
                            w_long_nxt  = 1'b1;
                            w_state_nxt = ST_LONG;
                        end else begin
                            w_hold_nxt = r_hold + c_HOLD_W'(1);
                        end
                    end
                end
                ST_LONG: begin
                    if (w_fall) begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_hold  <= '0;
                r_long  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_hold  <= w_hold_nxt;
                r_long  <= w_long_nxt;
            end
        end

`ifdef KEY_AUTO_REPEAT_EN
        localparam int c_RPT_W = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
        logic [c_RPT_W-1:0] r_rpt;
        logic               r_repeat;
        logic               w_rpt_step;
        logic               w_rpt_wrap;

        // rpt is held at zero outside LONG, so entering LONG always starts a fresh period.
        assign w_rpt_step = (r_state == ST_LONG) && w_tick && !w_fall;
        assign w_rpt_wrap = w_rpt_step && (r_rpt == c_RPT_W'(REPEAT_CNT - 1));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rpt    <= '0;
                r_repeat <= 1'b0;
            end else begin
                r_repeat <= w_rpt_wrap;
                if ((r_state != ST_LONG) || w_fall || w_rpt_wrap) r_rpt <= '0;
                else if (w_rpt_step)                              r_rpt <= r_rpt + c_RPT_W'(1);
            end
        end

        assign key_repeat[g] = r_repeat;
`else
        assign key_repeat[g] = 1'b0;
`endif

        assign key_level[g]   = r_level;
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;
        assign key_long[g]    = r_long;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_bank
// Description : Self-checking bench for key_debounce_bank against a cycle
//               reference model built from tick arithmetic and hold-time math.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_bank;

    localparam int NUM_KEYS   = 4;
    localparam int CLK_DIV    = 4;
    localparam int STABLE_CNT = 3;
    localparam int ACTIVE_LOW = 1;
    localparam int LONG_CNT   = 5;
    localparam int REPEAT_CNT = 2;
    localparam logic [3:0] RELEASED = 4'hF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] key_level, key_press, key_release, key_long, key_repeat;

    int checks = 0;
    int errors = 0;

    key_debounce_bank #(
        .NUM_KEYS  (NUM_KEYS),
        .CLK_DIV   (CLK_DIV),
        .STABLE_CNT(STABLE_CNT),
        .ACTIVE_LOW(ACTIVE_LOW),
        .LONG_CNT  (LONG_CNT),
        .REPEAT_CNT(REPEAT_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .key_repeat (key_repeat)
    );

    always #5 clk = ~clk;

    // Reference model: tick from the global cycle count, long/repeat from ticks held.
    int         m_cyc;
    bit         m_tick;
    logic       m_s;
    logic [3:0] m_p1, m_p2, m_level, e_press, e_release, e_long, e_repeat;
    int         m_run  [4];
    int         m_held [4];

    always @(posedge clk) begin
        if (rst) begin
            m_cyc = 0;
            m_p1 = RELEASED; m_p2 = RELEASED; m_level = '0;
            e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
            for (int k = 0; k < 4; k++) begin m_run[k] = 0; m_held[k] = -1; end
        end else begin
            m_tick = ((m_cyc % CLK_DIV) == CLK_DIV - 1);
            m_cyc++;
            e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
            for (int k = 0; k < 4; k++) begin
                if (m_tick) begin
                    m_s = m_p2[k] ^ (ACTIVE_LOW != 0);
                    if (m_s == m_level[k]) m_run[k] = 0;
                    else if (m_run[k] + 1 == STABLE_CNT) begin
                        m_run[k] = 0;
                        m_level[k] = m_s;
                        if (m_s) e_press[k] = 1'b1; else e_release[k] = 1'b1;
                    end else m_run[k]++;
                    if (e_release[k]) m_held[k] = -1;
                    else if (e_press[k]) m_held[k] = 0;
                    else if (m_held[k] >= 0) begin
                        m_held[k]++;
                        if (m_held[k] == LONG_CNT) e_long[k] = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                        else if (m_held[k] > LONG_CNT && ((m_held[k] - LONG_CNT) % REPEAT_CNT) == 0)
                            e_repeat[k] = 1'b1;
`endif
                    end
                end
            end
            m_p2 = m_p1;
            m_p1 = key;
        end
    end

    logic [19:0] dut_vec, exp_vec;
    assign dut_vec = {key_level, key_press, key_release, key_long, key_repeat};
    assign exp_vec = {m_level, e_press, e_release, e_long, e_repeat};

    task automatic test_reset();
        rst = 1'b1; key = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 20'h0) begin errors++; $display("FAIL reset_hold: got(lvl,prs,rel,lng,rpt)=%h want=%h", dut_vec, 20'h0); end
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL reset_model @%0t: got %h want %h", $time, dut_vec, exp_vec); end
            checks++;
            if (dut_vec !== 20'h0) begin errors++; $display("FAIL reset_quiet @%0t: got %h want 0", $time, dut_vec); end
        end
    endtask

    task automatic test_clean_press();
        int lat;
        repeat ($urandom_range(0, 7)) @(negedge clk);
        for (int phase = 0; phase < 2; phase++) begin
            lat = -1;
            key[0] = (phase == 1);
            for (int i = 1; i <= 30 && lat < 0; i++) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec) begin errors++; $display("FAIL clean_model @%0t: got %h want %h", $time, dut_vec, exp_vec); end
                if (key_level[0] == (phase == 0)) lat = i;
            end
            checks++;
            if (lat < 11 || lat > 14) begin errors++; $display("FAIL clean_latency phase%0d: got %0d clk want 11..14", phase, lat); end
            checks++;
            if (phase == 0 && key_press !== 4'b0001) begin errors++; $display("FAIL clean_press_pulse: got %b want 0001", key_press); end
            if (phase == 1 && key_release !== 4'b0001) begin errors++; $display("FAIL clean_release_pulse: got %b want 0001", key_release); end
            @(negedge clk);
            checks++;
            if (key_press[0] !== 1'b0 || key_release[0] !== 1'b0) begin
                errors++; $display("FAIL clean_pulse_width: got press=%b release=%b want 0 0", key_press[0], key_release[0]);
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 200; i++) begin
            if (i % 5 == 0) key[1] = ~key[1];
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL bounce_model @%0t: got %h want %h", $time, dut_vec, exp_vec); end
            checks++;
            if (key_level[1] !== 1'b0 || key_press[1] !== 1'b0) begin
                errors++; $display("FAIL bounce_level @%0t: got lvl=%b press=%b want 0 0", $time, key_level[1], key_press[1]);
            end
        end
        key[1] = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Leaves key[2] held in LONG for the mid-hold reset scenario.
    task automatic test_long_press();
        int t_press = -1, t_long = -1, t_last = -1, n_long = 0, n_rpt = 0;
        bit rpt_ok = 1'b1;
        key[2] = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL long_model @%0t: got %h want %h", $time, dut_vec, exp_vec); end
            if (key_press[2]) t_press = i;
            if (key_long[2]) begin
                n_long++; t_long = i;
                checks++;
                if (key_repeat[2] !== 1'b0) begin errors++; $display("FAIL long_repeat_coincident: got repeat=1 want 0"); end
            end
            if (key_repeat[2]) begin
                if (i - ((n_rpt == 0) ? t_long : t_last) != 4 * CLK_DIV / 2) rpt_ok = 1'b0;
                n_rpt++; t_last = i;
            end
        end
        checks++;
        if (n_long != 1) begin errors++; $display("FAIL long_count: got %0d want 1", n_long); end
        checks++;
        if (t_press < 0 || t_long - t_press != 20) begin errors++; $display("FAIL long_delay: got %0d clk want 20", t_long - t_press); end
`ifdef KEY_AUTO_REPEAT_EN
        checks++;
        if (!rpt_ok || n_rpt < 5) begin errors++; $display("FAIL repeat_spacing: got count=%0d spacing_ok=%0d want >=5, 1", n_rpt, rpt_ok); end
`else
        checks++;
        if (n_rpt != 0 || !rpt_ok) begin errors++; $display("FAIL repeat_disabled: got %0d pulses want 0", n_rpt); end
`endif
    endtask

    task automatic test_reset_mid_hold();
        int lat = -1, t_long = -1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== 20'h0) begin errors++; $display("FAIL midreset_clear: got %h want 0", dut_vec); end
        rst = 1'b0;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL midreset_model @%0t: got %h want %h", $time, dut_vec, exp_vec); end
            if (key_press[2]) lat = i;
        end
        checks++;
        if (lat < 11 || lat > 14) begin errors++; $display("FAIL midreset_press_latency: got %0d clk want 11..14", lat); end
        checks++;
        if (key_press !== 4'b0100) begin errors++; $display("FAIL midreset_press_bits: got %b want 0100", key_press); end
        for (int i = 1; i <= 40 && t_long < 0; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL midreset_model @%0t: got %h want %h", $time, dut_vec, exp_vec); end
            if (key_long[2]) t_long = i;
        end
        checks++;
        if (t_long != 20) begin errors++; $display("FAIL midreset_long_delay: got %0d clk want 20", t_long); end
        key[2] = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        bit seen = 1'b0;
        key = 4'h0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL simul_model @%0t: got %h want %h", $time, dut_vec, exp_vec); end
            seen = |key_press;
        end
        checks++;
        if (key_press !== 4'hF) begin errors++; $display("FAIL simul_press: got %b want 1111", key_press); end
        repeat (2) @(negedge clk);
        key[3] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL simul_model @%0t: got %h want %h", $time, dut_vec, exp_vec); end
            seen = |key_release;
        end
        checks++;
        if (key_release !== 4'h8) begin errors++; $display("FAIL simul_release: got %b want 1000", key_release); end
        key = 4'hF;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_random();
        int dwell [4];
        for (int k = 0; k < 4; k++) dwell[k] = $urandom_range(1, 60);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL random_model @%0t: got %h want %h", $time, dut_vec, exp_vec); end
            rst = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < 4; k++) begin
                dwell[k]--;
                if (dwell[k] <= 0) begin
                    key[k] = ~key[k];
                    dwell[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : $urandom_range(10, 140);
                end
            end
        end
        rst = 1'b0;
        key = 4'hF;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_reset_mid_hold();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
